// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC and keeps one request outstanding. L-cycle memory latency gives one instruction per L+1 cycles.
// Stall from decode parks a late response in a one-entry skid buffer. Redirects re-aim the PC and drop any stale response.
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            skid_vld_q, skid_vld_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;

  logic            redirect;
  logic [XLEN-1:0] target_raw;
  logic [XLEN-1:0] target;

  assign redirect   = jump | branch_taken;
  assign target_raw = jump ? jump_pc : branch_pc;
  assign target     = {target_raw[XLEN-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    skid_vld_d   = skid_vld_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;

    // Decode takes the current instruction; a load below may refill it.
    if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE:  state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            pc_d = pc_q + XLEN'(4);
            if (!if_valid_q || !stall) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              state_d    = ISSUE;
            end else begin
              skid_vld_d   = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          if_valid_d = skid_vld_q;
          if_instr_d = skid_instr_q;
          if_pc_d    = skid_pc_q;
          skid_vld_d = 1'b0;
          state_d    = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect wins over stall and normal flow; an in-flight request becomes stale.
    if (redirect) begin
      pc_d       = target;
      if_valid_d = 1'b0;
      skid_vld_d = 1'b0;
      unique case (state_q)
        ISSUE: begin
          drop_d  = 1'b1;
          state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ISSUE;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      skid_vld_q   <= skid_vld_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
    end
  end

  assign imem_req  = (state_q == ISSUE);
  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: variable-latency memory model plus an in-order scoreboard of fetched words.
module tb_instr_fetch_unit;

  logic        clk;
  logic        arst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic        jump;
  logic [31:0] jump_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .arst         (arst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .jump         (jump),
    .jump_pc      (jump_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: answers each request exactly mem_lat cycles later, regardless of DUT reset.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  end

  always @(posedge clk) begin
    #2;
    imem_rvalid = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
      end
    end
    if (imem_req === 1'b1) begin
      mem_cnt  = mem_lat;
      mem_addr = imem_addr;
    end
  end

  // Scoreboard: expected {pc, instr} pushed when a live response arrives, popped when decode consumes.
  logic [63:0] sb_q[$];
  logic        out_vld   = 1'b0;
  logic        out_stale = 1'b0;
  logic [31:0] out_addr  = '0;

  always @(negedge clk) begin
    logic [63:0] e;
    logic        redir;
    redir = jump | branch_taken;
    if (arst) begin
      sb_q.delete();
      out_vld = 1'b0;
    end else begin
      if (if_valid === 1'b1 && stall === 1'b0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_instr", if_pc, 32'hxxxx_xxxx);
        end else begin
          e = sb_q.pop_front();
          chk("sb_if_pc", if_pc, e[63:32]);
          chk("sb_if_instr", if_instr, e[31:0]);
        end
      end
      if (imem_rvalid && out_vld) begin
        if (!out_stale && !redir) sb_q.push_back({out_addr, mem_word(out_addr)});
        out_vld = 1'b0;
      end
      if (redir) begin
        sb_q.delete();
        out_stale = 1'b1;
      end
      if (imem_req === 1'b1) begin
        out_vld   = 1'b1;
        out_stale = redir;
        out_addr  = imem_addr;
      end
    end
  end

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(imem_req), 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  initial begin
    arst = 1'b1; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_pc = '0; branch_pc = '0;
    step(); step();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);

    // L=1 streaming from RESET_PC: cycle 0 is IDLE
    arst = 1'b0;
    chk("c0_imem_req", 32'(imem_req), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("c%0d_imem_req", k), 32'(imem_req), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k % 2 == 1) chk($sformatf("c%0d_imem_addr", k), imem_addr, 32'((k - 1) * 2));
      chk($sformatf("c%0d_if_valid", k), 32'(if_valid), (k >= 3 && k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 3 && k % 2 == 1) chk($sformatf("c%0d_if_pc", k), if_pc, 32'((k - 3) * 2));
    end

    // Stall for 5 cycles; response for pc 16 lands in the skid buffer
    step();
    stall = 1'b1;
    for (int j = 9; j <= 12; j++) begin
      step();
      chk($sformatf("stall_c%0d_if_valid", j), 32'(if_valid), 32'd1);
      chk($sformatf("stall_c%0d_if_pc", j), if_pc, 32'd12);
      if (j >= 11) chk($sformatf("hold_c%0d_no_req", j), 32'(imem_req), 32'd0);
    end
    step();
    stall = 1'b0;
    step();
    chk("unstall_if_valid", 32'(if_valid), 32'd1);
    chk("unstall_if_pc", if_pc, 32'd16);
    chk("unstall_imem_req", 32'(imem_req), 32'd1);
    chk("unstall_imem_addr", imem_addr, 32'd20);

    // Jump during WAIT with L=3
    mem_lat = 3;
    wait_req("jmp_wait_req");
    step(); step();
    jump = 1'b1; jump_pc = 32'h100;
    step();
    jump = 1'b0;
    chk("jmp_stale_if_valid", 32'(if_valid), 32'd0);
    chk("jmp_stale_no_req", 32'(imem_req), 32'd0);
    step();
    chk("jmp_if_valid_still0", 32'(if_valid), 32'd0);
    chk("jmp_imem_req", 32'(imem_req), 32'd1);
    chk("jmp_imem_addr", imem_addr, 32'h100);
    wait_valid("jmp_wait_valid");
    chk("jmp_if_pc", if_pc, 32'h100);

    // Jump beats branch, both coinciding with a response
    step(); step(); step();
    jump = 1'b1; jump_pc = 32'h80; branch_taken = 1'b1; branch_pc = 32'h40;
    step();
    jump = 1'b0; branch_taken = 1'b0;
    chk("prio_if_valid", 32'(if_valid), 32'd0);
    chk("prio_imem_req", 32'(imem_req), 32'd1);
    chk("prio_imem_addr", imem_addr, 32'h80);
    wait_valid("prio_wait_valid");
    chk("prio_if_pc", if_pc, 32'h80);

    // PC wrap at the top of the address space
    mem_lat = 1;
    jump = 1'b1; jump_pc = 32'hFFFF_FFFC;
    step();
    jump = 1'b0;
    wait_req("wrap_wait_req");
    chk("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    wait_valid("wrap_wait_valid");
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_next_req", 32'(imem_req), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Misaligned branch target is forced to a word boundary
    branch_taken = 1'b1; branch_pc = 32'h0000_0013;
    step();
    branch_taken = 1'b0;
    wait_req("align_wait_req");
    chk("align_imem_addr", imem_addr, 32'h10);
    step();
    wait_valid("align_wait_valid");
    chk("align_if_pc", if_pc, 32'h10);

    // Reset pulse during WAIT; the late response arrives while the FSM is in ISSUE
    mem_lat = 3;
    wait_req("arst_wait_req");
    step();
    arst = 1'b1;
    #1;
    chk("arst_if_valid", 32'(if_valid), 32'd0);
    chk("arst_if_pc", if_pc, 32'd0);
    chk("arst_if_instr", if_instr, 32'd0);
    chk("arst_imem_req", 32'(imem_req), 32'd0);
    step();
    arst = 1'b0;
    step();
    chk("arst_restart_req", 32'(imem_req), 32'd1);
    chk("arst_restart_addr", imem_addr, 32'h0);
    chk("arst_late_if_valid", 32'(if_valid), 32'd0);
    step();
    chk("arst_late_if_valid2", 32'(if_valid), 32'd0);
    wait_valid("arst_wait_valid");
    chk("arst_if_pc0", if_pc, 32'h0);

    mem_lat = 1;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
